// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_e;

    // Wide enough for the largest supported timeout of 1023 BUSY cycles.
    localparam int TMO_CNT_W = 10;

endpackage

// File: rtl/mem_arb_timeout.sv
// Loadable up-counter used to bound how long the arbiter waits for a memory ack.
// The terminal count marks the last BUSY cycle before the wait is declared a timeout.
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clock__i,
    input  logic                 reset__i,
    input  logic                 clear__i,
    input  logic                 enable__i,
    input  logic                 load__i,
    input  logic [TMO_CNT_W-1:0] load_val__i,
    output logic                 tc__o
);

    // The count holds the number of ack-less BUSY cycles already completed,
    // so the final allowed cycle is the one that sees TIMEOUT_CYCLES-1.
    localparam logic [TMO_CNT_W-1:0] TC_VAL = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_CNT_W-1:0] count_q;
    logic [TMO_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear__i) begin
            count_d = '0;
        end else if (load__i) begin
            count_d = load_val__i;
        end else if (enable__i) begin
            count_d = count_q + TMO_CNT_W'(1);
        end
    end

    always_ff @(posedge clock__i or posedge reset__i) begin
        if (reset__i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc__o = (count_q == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage, running a
// registered request/ack handshake to memory and reporting stalls and timeouts.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock__i,
    input  logic                  reset__i,
    input  logic                  if_req__i,
    input  logic [ADDR_WIDTH-1:0] if_addr__i,
    output logic [DATA_WIDTH-1:0] if_rdata__o,
    output logic                  if_ack__o,
    input  logic                  dm_req__i,
    input  logic                  dm_we__i,
    input  logic [ADDR_WIDTH-1:0] dm_addr__i,
    input  logic [DATA_WIDTH-1:0] dm_wdata__i,
    output logic [DATA_WIDTH-1:0] dm_rdata__o,
    output logic                  dm_ack__o,
    output logic                  mem_req__o,
    output logic                  mem_we__o,
    output logic [ADDR_WIDTH-1:0] mem_addr__o,
    output logic [DATA_WIDTH-1:0] mem_wdata__o,
    input  logic [DATA_WIDTH-1:0] mem_rdata__i,
    input  logic                  mem_ack__i,
    output logic                  stall__o,
    output logic                  err__o
);

    // Handshakes: a requester holds req and its operands level until its ack
    // pulses for one cycle; mem_req and operands stay stable until mem_ack.
    arb_state_e            state_q, state_d;
    grant_e                last_q, last_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  if_ack_q, if_ack_d;
    logic                  dm_ack_q, dm_ack_d;
    logic                  err_q, err_d;
    logic                  pick_dm;
    logic                  tmo_clear;
    logic                  tmo_en;
    logic                  tmo_tc;

    mem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock__i   (clock__i),
        .reset__i   (reset__i),
        .clear__i   (tmo_clear),
        .enable__i  (tmo_en),
        .load__i    (1'b0),
        .load_val__i('0),
        .tc__o      (tmo_tc)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        err_d       = err_q;
        pick_dm     = 1'b0;
        tmo_clear   = 1'b0;
        tmo_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req__i || dm_req__i) begin
                    // Under contention the side not served last wins.
                    pick_dm     = dm_req__i && (!if_req__i || last_q == GRANT_IF);
                    last_d      = pick_dm ? GRANT_DM : GRANT_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = pick_dm && dm_we__i;
                    mem_addr_d  = pick_dm ? dm_addr__i : if_addr__i;
                    mem_wdata_d = pick_dm ? dm_wdata__i : '0;
                    tmo_clear   = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack__i) begin
                    if (last_q == GRANT_DM) begin
                        dm_rdata_d = mem_rdata__i;
                        dm_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata__i;
                        if_ack_d   = 1'b1;
                    end
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end else if (tmo_tc) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ERR;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock__i or posedge reset__i) begin
        if (reset__i) begin
            state_q     <= IDLE;
            last_q      <= GRANT_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            err_q       <= err_d;
        end
    end

    assign mem_req__o   = mem_req_q;
    assign mem_we__o    = mem_we_q;
    assign mem_addr__o  = mem_addr_q;
    assign mem_wdata__o = mem_wdata_q;
    assign if_rdata__o  = if_rdata_q;
    assign dm_rdata__o  = dm_rdata_q;
    assign if_ack__o    = if_ack_q;
    assign dm_ack__o    = dm_ack_q;
    assign err__o       = err_q;
    assign stall__o     = (if_req__i & ~if_ack_q) | (dm_req__i & ~dm_ack_q) | err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of the memory port arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int RAND_N = 25;

    logic        clock__i = 1'b0;
    logic        reset__i = 1'b1;
    logic        if_req__i = 1'b0;
    logic [31:0] if_addr__i = '0;
    logic [31:0] if_rdata__o;
    logic        if_ack__o;
    logic        dm_req__i = 1'b0;
    logic        dm_we__i = 1'b0;
    logic [31:0] dm_addr__i = '0;
    logic [31:0] dm_wdata__i = '0;
    logic [31:0] dm_rdata__o;
    logic        dm_ack__o;
    logic        mem_req__o;
    logic        mem_we__o;
    logic [31:0] mem_addr__o;
    logic [31:0] mem_wdata__o;
    logic [31:0] mem_rdata__i = '0;
    logic        mem_ack__i = 1'b0;
    logic        stall__o;
    logic        err__o;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    bit          exp_load_q[$];
    logic [31:0] mem_arr[16];
    logic [31:0] ref_mem[16];

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock__i    (clock__i),
        .reset__i    (reset__i),
        .if_req__i   (if_req__i),
        .if_addr__i  (if_addr__i),
        .if_rdata__o (if_rdata__o),
        .if_ack__o   (if_ack__o),
        .dm_req__i   (dm_req__i),
        .dm_we__i    (dm_we__i),
        .dm_addr__i  (dm_addr__i),
        .dm_wdata__i (dm_wdata__i),
        .dm_rdata__o (dm_rdata__o),
        .dm_ack__o   (dm_ack__o),
        .mem_req__o  (mem_req__o),
        .mem_we__o   (mem_we__o),
        .mem_addr__o (mem_addr__o),
        .mem_wdata__o(mem_wdata__o),
        .mem_rdata__i(mem_rdata__i),
        .mem_ack__i  (mem_ack__i),
        .stall__o    (stall__o),
        .err__o      (err__o)
    );

    always #5 clock__i = ~clock__i;

    task automatic step();
        @(posedge clock__i);
        #1;
    endtask

    task automatic do_reset();
        reset__i = 1'b1;
        if_req__i = 1'b0;
        dm_req__i = 1'b0;
        dm_we__i = 1'b0;
        if_addr__i = '0;
        dm_addr__i = '0;
        dm_wdata__i = '0;
        mem_ack__i = 1'b0;
        mem_rdata__i = '0;
        step();
        step();
        reset__i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_req__o, mem_we__o, mem_addr__o, mem_wdata__o, if_ack__o, dm_ack__o,
             if_rdata__o, dm_rdata__o, err__o, stall__o} !== '0)
            begin errors++; $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h err=%b stall=%b required all zero",
                mem_req__o, mem_we__o, mem_addr__o, mem_wdata__o, err__o, stall__o); end
        step();
        checks++;
        if ({mem_req__o, if_ack__o, dm_ack__o, stall__o} !== 4'b0000)
            begin errors++; $display("FAIL reset_idle: got req=%b ifack=%b dmack=%b stall=%b required 0000",
                mem_req__o, if_ack__o, dm_ack__o, stall__o); end
    endtask

    task automatic test_if_fetch();
        do_reset();
        if_req__i = 1'b1;
        if_addr__i = 32'h100;
        step();
        checks++;
        if ({mem_req__o, mem_we__o, mem_addr__o, if_ack__o} !== {1'b1, 1'b0, 32'h100, 1'b0})
            begin errors++; $display("FAIL if_grant: got req=%b we=%b addr=%h ack=%b required 1 0 00000100 0",
                mem_req__o, mem_we__o, mem_addr__o, if_ack__o); end
        checks++;
        if (stall__o !== 1'b1) begin errors++; $display("FAIL if_stall_busy: got %b required 1", stall__o); end
        mem_ack__i = 1'b1;
        mem_rdata__i = 32'hDEADBEEF;
        step();
        checks++;
        if ({if_ack__o, if_rdata__o, mem_req__o, dm_ack__o, stall__o} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0})
            begin errors++; $display("FAIL if_resp: got ack=%b rdata=%h req=%b dmack=%b stall=%b required 1 deadbeef 0 0 0",
                if_ack__o, if_rdata__o, mem_req__o, dm_ack__o, stall__o); end
        mem_ack__i = 1'b0;
        mem_rdata__i = 32'h11111111;
        if_req__i = 1'b0;
        step();
        checks++;
        if ({if_ack__o, stall__o, mem_req__o, if_rdata__o} !== {1'b0, 1'b0, 1'b0, 32'hDEADBEEF})
            begin errors++; $display("FAIL if_after: got ack=%b stall=%b req=%b rdata=%h required 0 0 0 deadbeef",
                if_ack__o, stall__o, mem_req__o, if_rdata__o); end
    endtask

    task automatic test_dm_store();
        do_reset();
        dm_req__i = 1'b1;
        dm_we__i = 1'b1;
        dm_addr__i = 32'h200;
        dm_wdata__i = 32'h12345678;
        step();
        dm_addr__i = 32'hFFC;
        dm_wdata__i = 32'h0;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if ({mem_req__o, mem_we__o, mem_addr__o, mem_wdata__o, if_ack__o, dm_ack__o} !==
                {1'b1, 1'b1, 32'h200, 32'h12345678, 1'b0, 1'b0})
                begin errors++; $display("FAIL dm_busy_stable[%0d]: got req=%b we=%b addr=%h wdata=%h acks=%b%b required 1 1 00000200 12345678 00",
                    k, mem_req__o, mem_we__o, mem_addr__o, mem_wdata__o, if_ack__o, dm_ack__o); end
            mem_ack__i = (k == 3);
            step();
        end
        checks++;
        if ({dm_ack__o, if_ack__o, mem_req__o} !== 3'b100)
            begin errors++; $display("FAIL dm_resp: got dmack=%b ifack=%b req=%b required 1 0 0",
                dm_ack__o, if_ack__o, mem_req__o); end
        mem_ack__i = 1'b0;
        dm_req__i = 1'b0;
        step();
        checks++;
        if ({dm_ack__o, if_ack__o} !== 2'b00)
            begin errors++; $display("FAIL dm_ack_pulse: got dmack=%b ifack=%b required 0 0", dm_ack__o, if_ack__o); end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        dm_req__i = 1'b1;
        dm_addr__i = 32'h40;
        step();
        checks++;
        if ({mem_req__o, mem_addr__o} !== {1'b1, 32'h40})
            begin errors++; $display("FAIL midbusy_grant: got req=%b addr=%h required 1 00000040", mem_req__o, mem_addr__o); end
        step();
        reset__i = 1'b1;
        dm_req__i = 1'b0;
        #1;
        checks++;
        if ({mem_req__o, mem_we__o, mem_addr__o, mem_wdata__o, if_ack__o, dm_ack__o,
             if_rdata__o, dm_rdata__o, err__o, stall__o} !== '0)
            begin errors++; $display("FAIL midbusy_reset: got req=%b addr=%h err=%b stall=%b required all zero",
                mem_req__o, mem_addr__o, err__o, stall__o); end
        step();
        reset__i = 1'b0;
        if_req__i = 1'b1;
        if_addr__i = 32'h300;
        step();
        checks++;
        if ({mem_req__o, mem_we__o, mem_addr__o} !== {1'b1, 1'b0, 32'h300})
            begin errors++; $display("FAIL midbusy_regrant: got req=%b we=%b addr=%h required 1 0 00000300",
                mem_req__o, mem_we__o, mem_addr__o); end
        mem_ack__i = 1'b1;
        mem_rdata__i = 32'hCAFE0001;
        step();
        checks++;
        if ({if_ack__o, if_rdata__o} !== {1'b1, 32'hCAFE0001})
            begin errors++; $display("FAIL midbusy_resp: got ack=%b rdata=%h required 1 cafe0001", if_ack__o, if_rdata__o); end
        mem_ack__i = 1'b0;
        if_req__i = 1'b0;
        step();
    endtask

    task automatic test_alternation();
        int  grants;
        int  last_cyc;
        bit  exp_dm;
        bit  side_dm;
        bit  prev_req;
        bit  prev_if_ack;
        bit  prev_dm_ack;
        do_reset();
        if_req__i = 1'b1;
        if_addr__i = 32'h1000;
        dm_req__i = 1'b1;
        dm_we__i = 1'b0;
        dm_addr__i = 32'h2000;
        exp_dm = 1'b1;
        side_dm = 1'b0;
        grants = 0;
        last_cyc = 0;
        prev_req = 1'b0;
        prev_if_ack = 1'b0;
        prev_dm_ack = 1'b0;
        for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
            step();
            if (mem_req__o === 1'b1 && !prev_req) begin
                checks++;
                if (mem_addr__o !== (exp_dm ? 32'h2000 : 32'h1000))
                    begin errors++; $display("FAIL alt_order[%0d]: got addr=%h required %h",
                        grants, mem_addr__o, exp_dm ? 32'h2000 : 32'h1000); end
                if (grants > 0) begin
                    checks++;
                    if (cyc - last_cyc !== 3)
                        begin errors++; $display("FAIL alt_spacing[%0d]: got %0d cycles required 3", grants, cyc - last_cyc); end
                end
                side_dm = exp_dm;
                last_cyc = cyc;
                grants++;
                exp_dm = !exp_dm;
            end
            if (if_ack__o || dm_ack__o) begin
                checks++;
                if ({if_ack__o, dm_ack__o} !== {!side_dm, side_dm})
                    begin errors++; $display("FAIL alt_ack_side: got ifack=%b dmack=%b required %b %b",
                        if_ack__o, dm_ack__o, !side_dm, side_dm); end
            end
            checks++;
            if ((if_ack__o && prev_if_ack) || (dm_ack__o && prev_dm_ack))
                begin errors++; $display("FAIL alt_ack_width: got ack high two cycles required one"); end
            prev_if_ack = if_ack__o;
            prev_dm_ack = dm_ack__o;
            prev_req = mem_req__o;
            mem_ack__i = mem_req__o;
            mem_rdata__i = 32'(cyc);
        end
        checks++;
        if (grants !== 6) begin errors++; $display("FAIL alt_grants: got %0d required 6", grants); end
        if_req__i = 1'b0;
        dm_req__i = 1'b0;
        mem_ack__i = 1'b0;
        step();
        step();
    endtask

    task automatic test_timeout();
        bit exp_err;
        do_reset();
        if_req__i = 1'b1;
        if_addr__i = 32'h80;
        step();
        checks++;
        if ({mem_req__o, err__o} !== 2'b10)
            begin errors++; $display("FAIL tmo_grant: got req=%b err=%b required 1 0", mem_req__o, err__o); end
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_err = (k == 4);
            checks++;
            if ({err__o, mem_req__o} !== {exp_err, !exp_err})
                begin errors++; $display("FAIL tmo_cycle[%0d]: got err=%b req=%b required %b %b",
                    k, err__o, mem_req__o, exp_err, !exp_err); end
        end
        if_req__i = 1'b0;
        step();
        checks++;
        if ({stall__o, if_ack__o} !== 2'b10)
            begin errors++; $display("FAIL tmo_stall: got stall=%b ack=%b required 1 0", stall__o, if_ack__o); end
        mem_ack__i = 1'b1;
        mem_rdata__i = 32'h77777777;
        dm_req__i = 1'b1;
        dm_addr__i = 32'h44;
        step();
        step();
        checks++;
        if ({if_ack__o, dm_ack__o, mem_req__o, err__o, stall__o} !== 5'b00011)
            begin errors++; $display("FAIL tmo_terminal: got ifack=%b dmack=%b req=%b err=%b stall=%b required 0 0 0 1 1",
                if_ack__o, dm_ack__o, mem_req__o, err__o, stall__o); end
        do_reset();
        checks++;
        if ({err__o, stall__o} !== 2'b00)
            begin errors++; $display("FAIL tmo_reset_clear: got err=%b stall=%b required 0 0", err__o, stall__o); end
    endtask

    task automatic test_stray_ack();
        do_reset();
        mem_ack__i = 1'b1;
        mem_rdata__i = 32'h55555555;
        step();
        step();
        checks++;
        if ({if_ack__o, dm_ack__o, mem_req__o, stall__o, if_rdata__o, dm_rdata__o} !== '0)
            begin errors++; $display("FAIL stray_idle: got ifack=%b dmack=%b req=%b stall=%b ifrd=%h dmrd=%h required all zero",
                if_ack__o, dm_ack__o, mem_req__o, stall__o, if_rdata__o, dm_rdata__o); end
        mem_ack__i = 1'b0;
        if_req__i = 1'b1;
        if_addr__i = 32'h10;
        step();
        mem_ack__i = 1'b1;
        mem_rdata__i = 32'hA5A5A5A5;
        step();
        checks++;
        if ({if_ack__o, if_rdata__o} !== {1'b1, 32'hA5A5A5A5})
            begin errors++; $display("FAIL stray_fetch: got ack=%b rdata=%h required 1 a5a5a5a5", if_ack__o, if_rdata__o); end
        mem_rdata__i = 32'h0BAD0BAD;
        if_req__i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({if_ack__o, dm_ack__o, mem_req__o, if_rdata__o} !== {1'b0, 1'b0, 1'b0, 32'hA5A5A5A5})
                begin errors++; $display("FAIL stray_resp[%0d]: got ifack=%b dmack=%b req=%b rdata=%h required 0 0 0 a5a5a5a5",
                    k, if_ack__o, dm_ack__o, mem_req__o, if_rdata__o); end
        end
        mem_ack__i = 1'b0;
    endtask

    task automatic test_random();
        int          if_cnt, dm_cnt, if_done, dm_done, resp_wait, bad_words;
        bit          last_dm, cur_dm, side_dm, ack_due, prev_req;
        bit          exp_if_ack, exp_dm_ack, if_acked, dm_acked, is_load;
        logic [31:0] exp_word;
        logic [31:0] got_word;
        logic [3:0]  idx;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        exp_q.delete();
        exp_load_q.delete();
        if_cnt = 0; dm_cnt = 0; if_done = 0; dm_done = 0; resp_wait = -1;
        last_dm = 1'b0; cur_dm = 1'b0; ack_due = 1'b0; prev_req = 1'b0;
        for (int cyc = 0; cyc < 4000 && !(if_done == RAND_N && dm_done == RAND_N); cyc++) begin
            step();
            if_acked = 1'b0;
            dm_acked = 1'b0;
            exp_if_ack = ack_due & ~cur_dm;
            exp_dm_ack = ack_due & cur_dm;
            checks++;
            if ({if_ack__o, dm_ack__o} !== {exp_if_ack, exp_dm_ack})
                begin errors++; $display("FAIL rand_ack[%0d]: got ifack=%b dmack=%b required %b %b",
                    cyc, if_ack__o, dm_ack__o, exp_if_ack, exp_dm_ack); end
            checks++;
            if (stall__o !== ((if_req__i & ~exp_if_ack) | (dm_req__i & ~exp_dm_ack)))
                begin errors++; $display("FAIL rand_stall[%0d]: got %b required %b", cyc, stall__o,
                    (if_req__i & ~exp_if_ack) | (dm_req__i & ~exp_dm_ack)); end
            if (ack_due) begin
                if (exp_q.size() > 0) begin
                    is_load = exp_load_q.pop_front();
                    exp_word = exp_q.pop_front();
                    got_word = cur_dm ? dm_rdata__o : if_rdata__o;
                    if (is_load) begin
                        checks++;
                        if (got_word !== exp_word)
                            begin errors++; $display("FAIL rand_rdata[%0d]: got %h required %h (dm=%b)",
                                cyc, got_word, exp_word, cur_dm); end
                    end
                end
                if (cur_dm) begin dm_done++; dm_acked = 1'b1; end
                else begin if_done++; if_acked = 1'b1; end
            end
            if (mem_req__o === 1'b1 && !prev_req) begin
                side_dm = (if_req__i && dm_req__i) ? !last_dm : dm_req__i;
                checks++;
                if (!(if_req__i || dm_req__i))
                    begin errors++; $display("FAIL rand_spurious_grant[%0d]: got grant required none", cyc); end
                checks++;
                if (side_dm ? ({mem_we__o, mem_addr__o, mem_wdata__o} !== {dm_we__i, dm_addr__i, dm_wdata__i})
                            : ({mem_we__o, mem_addr__o} !== {1'b0, if_addr__i}))
                    begin errors++; $display("FAIL rand_grant[%0d]: got we=%b addr=%h wdata=%h required side dm=%b we=%b addr=%h",
                        cyc, mem_we__o, mem_addr__o, mem_wdata__o, side_dm,
                        side_dm & dm_we__i, side_dm ? dm_addr__i : if_addr__i); end
                idx = side_dm ? dm_addr__i[5:2] : if_addr__i[5:2];
                is_load = !(side_dm && dm_we__i);
                exp_q.push_back(ref_mem[idx]);
                exp_load_q.push_back(is_load);
                if (!is_load) ref_mem[idx] = dm_wdata__i;
                last_dm = side_dm;
                cur_dm = side_dm;
            end
            prev_req = mem_req__o;
            ack_due = 1'b0;
            mem_ack__i = 1'b0;
            mem_rdata__i = $urandom;
            if (mem_req__o) begin
                if (resp_wait < 0) resp_wait = $urandom_range(0, 2);
                if (resp_wait == 0) begin
                    mem_ack__i = 1'b1;
                    mem_rdata__i = mem_arr[mem_addr__o[5:2]];
                    if (mem_we__o) mem_arr[mem_addr__o[5:2]] = mem_wdata__o;
                    ack_due = 1'b1;
                    resp_wait = -1;
                end else begin
                    resp_wait--;
                end
            end else begin
                resp_wait = -1;
            end
            if (if_acked) if_req__i = 1'b0;
            if (dm_acked) dm_req__i = 1'b0;
            if (!if_req__i && if_cnt < RAND_N && $urandom_range(0, 2) != 0) begin
                if_req__i = 1'b1;
                if_addr__i = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                if_cnt++;
            end
            if (!dm_req__i && dm_cnt < RAND_N && $urandom_range(0, 2) != 0) begin
                dm_req__i = 1'b1;
                dm_we__i = 1'($urandom_range(0, 1));
                dm_addr__i = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                dm_wdata__i = $urandom;
                dm_cnt++;
            end
        end
        checks++;
        if (if_done != RAND_N || dm_done != RAND_N)
            begin errors++; $display("FAIL rand_complete: got if=%0d dm=%0d required %0d each", if_done, dm_done, RAND_N); end
        checks++;
        if (exp_q.size() != 0)
            begin errors++; $display("FAIL rand_leftover: got %0d outstanding required 0", exp_q.size()); end
        bad_words = 0;
        for (int i = 0; i < 16; i++) if (mem_arr[i] !== ref_mem[i]) bad_words++;
        checks++;
        if (bad_words != 0)
            begin errors++; $display("FAIL rand_memory: got %0d differing words required 0", bad_words); end
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_dm_store();
        test_reset_mid_busy();
        test_alternation();
        test_timeout();
        test_stray_ack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
